pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage ARM-subset pipeline. It drives the hold and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects RAW hazards between the ID stage and the EX/MEM destinations, handles taken-branch flushes, and freezes the whole pipe while the SRAM memory port is busy. Performance and error status is kept for debug readout.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before forced exit and error flag (2..65535)
CNT_W, 16, width of saturating performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
src1  in  4  ID-stage Rn index
src2  in  4  ID-stage Rm/Rd(store) index
use_src1  in  1  ID instruction reads src1
two_src  in  1  ID instruction reads src2
exe_dest  in  4  ID/EX register Rd
exe_wb_en  in  1  ID/EX register write-back enable
exe_mem_read  in  1  ID/EX register is a load
mem_dest  in  4  EX/MEM register Rd
mem_wb_en  in  1  EX/MEM register write-back enable
branch_taken  in  1  EX-stage B resolved taken
mem_req  in  1  MEM stage issues read or write this cycle
mem_ready  in  1  SRAM completes access this cycle
freeze_if  out  1  hold PC and IF/ID
flush_if  out  1  zero IF/ID
flush_id  out  1  zero ID/EX (bubble)
freeze_exe  out  1  hold ID/EX and EX/MEM
freeze_mem  out  1  hold MEM/WB, suppress WB enable
stall_cnt  out  CNT_W  cycles with freeze_if=1, saturating
flush_cnt  out  CNT_W  taken-branch flush events, saturating
timeout_err  out  1  sticky: MEM_WAIT timeout occurred

Behaviour:
- States: RUN, MEM_WAIT. Reset gives state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, timeout_err=0. All control outputs are 0 while rst=1.
- Control outputs are combinational from the current state and inputs, so the pipeline registers see them in the same cycle. Only state, counters and the error flag are registered.
- mem_busy = mem_req & ~mem_ready in RUN. It is ~mem_ready in MEM_WAIT.
- hazard = (use_src1 & match(src1)) | (two_src & match(src2)).
- Without the optional feature: match(r) = (exe_wb_en & r==exe_dest) | (mem_wb_en & r==mem_dest).
- Priority 1, mem_busy: freeze_if=freeze_exe=freeze_mem=1, all flushes=0. Branch and hazard are ignored this cycle and re-evaluate when the pipe advances.
- Priority 2, branch_taken: flush_if=1, flush_id=1, freezes=0. flush_cnt increments.
- Priority 3, hazard: freeze_if=1, flush_id=1 (bubble), freeze_exe=freeze_mem=0.
- Otherwise all outputs are 0.
- RUN→MEM_WAIT when mem_req & ~mem_ready. The wait counter loads 1.
- MEM_WAIT→RUN when mem_ready=1. In that cycle outputs are released and the pipe advances.
- MEM_WAIT holds while mem_ready=0 and the wait counter increments.
- Timeout: if the wait counter reaches MEM_TIMEOUT with mem_ready=0, the next state is RUN and timeout_err is set (sticky until rst). The timeout cycle still freezes. The following cycle releases even if mem_ready=0.
- mem_req=0 while in MEM_WAIT has no effect. The SRAM owns completion.
- stall_cnt increments on every cycle with freeze_if=1, saturating at all-ones. flush_cnt saturates likewise.
- rst mid-MEM_WAIT returns to RUN in the next cycle with all counters cleared.
- Index compare is exact 4-bit. R15 gets no special treatment.

Optional Feature:
FORWARDING_EN
- Defined: the forwarding unit exists, so match(r) = exe_mem_read & exe_wb_en & r==exe_dest. Only load-use stalls remain, for exactly one cycle. The MEM-stage compare is removed.
- Undefined: full EX+MEM RAW compare as above. A dependent instruction stalls up to 2 cycles.

Test Plan:
- Reset: hold rst=1 with mem_req=1, branch_taken=1 → all outputs 0. After release: stall_cnt=0, flush_cnt=0, timeout_err=0.
- RAW hazard: src1=3, use_src1=1, exe_dest=3, exe_wb_en=1 → freeze_if=1, flush_id=1 for 1 cycle. Without FORWARDING_EN, next cycle with mem_dest=3, mem_wb_en=1 → stall again. With FORWARDING_EN and exe_mem_read=0 → no stall.
- Branch vs hazard: branch_taken=1 together with a src2 hazard → flush_if=1, flush_id=1, freeze_if=0. flush_cnt goes 0→1.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 → all three freezes high for 4 cycles, released in cycle 5. stall_cnt=4.
- Timeout: MEM_TIMEOUT=8, mem_ready held 0 → freezes for 8 cycles, then release. timeout_err=1 stays set until rst.
- Saturation: CNT_W=4, 20 hazard cycles → stall_cnt=15.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB controls).
// Latency: control outputs are combinational from state + inputs (same cycle); counters/flags registered.
// Backpressure: SRAM busy freezes the whole pipe; taken branch flushes IF/ID+ID/EX; RAW hazard inserts a bubble.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   src1/src2, use_src1/two_src           - ID-stage source indices and their use flags
//   exe_dest/exe_wb_en/exe_mem_read       - ID/EX destination, write-back enable, load flag
//   mem_dest/mem_wb_en       - EX/MEM destination and write-back enable
//   branch_taken             - EX-stage branch resolved taken
//   mem_req/mem_ready        - MEM-stage SRAM request and completion
//   freeze_if/flush_if/flush_id/freeze_exe/freeze_mem - pipeline register controls
//   stall_cnt/flush_cnt      - saturating debug counters
//   timeout_err              - sticky SRAM wait timeout flag
// Build option: define FORWARDING_EN when a forwarding unit exists; only load-use hazards then stall.
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             use_src1,
  input  logic             two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             flush_id,
  output logic             freeze_exe,
  output logic             freeze_mem,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // The RUN cycle that enters MEM_WAIT counts as wait cycle 1, so the timeout
  // fires in the MEM_WAIT cycle whose counter is one short of MEM_TIMEOUT.
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic             rel_q, rel_d;     // forced-release cycle after a timeout
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             err_q, err_d;

  logic match1, match2, hazard, mem_busy, timeout;

`ifdef FORWARDING_EN
  // Forwarding covers everything except a load whose data is not yet read.
  assign match1 = exe_mem_read & exe_wb_en & (src1 == exe_dest);
  assign match2 = exe_mem_read & exe_wb_en & (src2 == exe_dest);
  logic unused_mem_stage;
  assign unused_mem_stage = ^{mem_dest, mem_wb_en};
`else
  assign match1 = (exe_wb_en & (src1 == exe_dest)) | (mem_wb_en & (src1 == mem_dest));
  assign match2 = (exe_wb_en & (src2 == exe_dest)) | (mem_wb_en & (src2 == mem_dest));
  logic unused_load_flag;
  assign unused_load_flag = exe_mem_read;
`endif

  assign hazard = (use_src1 & match1) | (two_src & match2);

  // In MEM_WAIT the SRAM alone decides completion; mem_req is irrelevant there.
  always_comb begin
    mem_busy = 1'b0;
    case (state_q)
      RUN:      mem_busy = mem_req & ~mem_ready & ~rel_q;
      MEM_WAIT: mem_busy = ~mem_ready;
      default:  mem_busy = 1'b0;
    endcase
  end

  assign timeout = (state_q == MEM_WAIT) & ~mem_ready & (wait_q == WAIT_LAST);

  // Priority: memory busy > taken branch > RAW hazard.
  always_comb begin
    freeze_if  = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    freeze_exe = 1'b0;
    freeze_mem = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        freeze_if  = 1'b1;
        freeze_exe = 1'b1;
        freeze_mem = 1'b1;
      end else if (branch_taken) begin
        flush_if = 1'b1;
        flush_id = 1'b1;
      end else if (hazard) begin
        freeze_if = 1'b1;
        flush_id  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rel_d   = 1'b0;
    err_d   = err_q | timeout;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = MEM_WAIT;
          wait_d  = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
          wait_d  = 16'd0;
        end else if (timeout) begin
          state_d = RUN;
          wait_d  = 16'd0;
          rel_d   = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = 16'd0;
      end
    endcase
  end

  // Saturating debug counters; a branch only counts when it actually flushes.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (freeze_if && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
    if (flush_if && (flush_q != {CNT_W{1'b1}})) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= 16'd0;
      rel_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rel_q   <= rel_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  localparam int CNT_W = 4;
  localparam int MEM_TIMEOUT = 8;

  // ctrl = {freeze_if, flush_if, flush_id, freeze_exe, freeze_mem}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_MEM  = 5'b10011;
  localparam logic [4:0] C_BR   = 5'b01100;
  localparam logic [4:0] C_HZ   = 5'b10100;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] src1, src2, exe_dest, mem_dest;
  logic use_src1, two_src, exe_wb_en, exe_mem_read, mem_wb_en;
  logic branch_taken, mem_req, mem_ready;
  logic freeze_if, flush_if, flush_id, freeze_exe, freeze_mem;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic timeout_err;
  logic [4:0] ctrl;

  int total = 0;
  int bad = 0;

  assign ctrl = {freeze_if, flush_if, flush_id, freeze_exe, freeze_mem};

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .src1(src1), .src2(src2), .use_src1(use_src1), .two_src(two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_if(freeze_if), .flush_if(flush_if), .flush_id(flush_id),
    .freeze_exe(freeze_exe), .freeze_mem(freeze_mem),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .timeout_err(timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src1 = 4'd0; src2 = 4'd0; use_src1 = 1'b0; two_src = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1; mem_req = 1'b1; branch_taken = 1'b1;
    src1 = 4'd2; use_src1 = 1'b1; exe_dest = 4'd2; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
    step();
    total++;
    if (ctrl !== C_NONE) begin bad++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, C_NONE); end
    step();
    clear_inputs();
    rst = 1'b0;
    #1;
    total++;
    if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
    total++;
    if (flush_cnt !== 4'd0) begin bad++; $display("FAIL reset_flush got=%0d want=0", flush_cnt); end
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", timeout_err); end
    total++;
    if (ctrl !== C_NONE) begin bad++; $display("FAIL idle_ctrl got=%b want=%b", ctrl, C_NONE); end
  endtask

  task automatic test_raw();
    logic [4:0] exp1, exp2;
    logic [CNT_W-1:0] exp_stalls;
`ifdef FORWARDING_EN
    exp1 = C_NONE; exp2 = C_NONE; exp_stalls = 4'd1;
`else
    exp1 = C_HZ;   exp2 = C_HZ;   exp_stalls = 4'd3;
`endif
    do_reset();
    // EX-stage producer, not a load
    src1 = 4'd3; use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b0;
    #1;
    total++;
    if (ctrl !== exp1) begin bad++; $display("FAIL raw_exe got=%b want=%b", ctrl, exp1); end
    step();
    // producer has moved on to MEM
    exe_wb_en = 1'b0; exe_dest = 4'd0; mem_dest = 4'd3; mem_wb_en = 1'b1;
    #1;
    total++;
    if (ctrl !== exp2) begin bad++; $display("FAIL raw_mem got=%b want=%b", ctrl, exp2); end
    step();
    // load-use on R15 via src2: stalls in both builds
    mem_wb_en = 1'b0; use_src1 = 1'b0;
    src2 = 4'd15; two_src = 1'b1; exe_dest = 4'd15; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
    #1;
    total++;
    if (ctrl !== C_HZ) begin bad++; $display("FAIL raw_load_r15 got=%b want=%b", ctrl, C_HZ); end
    step();
    // same index but the operand is not read: no stall
    two_src = 1'b0; src1 = 4'd15; use_src1 = 1'b0;
    #1;
    total++;
    if (ctrl !== C_NONE) begin bad++; $display("FAIL raw_unused_src got=%b want=%b", ctrl, C_NONE); end
    total++;
    if (stall_cnt !== exp_stalls) begin bad++; $display("FAIL raw_stall_cnt got=%0d want=%0d", stall_cnt, exp_stalls); end
    step();
    clear_inputs();
  endtask

  task automatic test_branch_vs_hazard();
    do_reset();
    branch_taken = 1'b1;
    src2 = 4'd5; two_src = 1'b1; exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
    #1;
    total++;
    if (ctrl !== C_BR) begin bad++; $display("FAIL branch_ctrl got=%b want=%b", ctrl, C_BR); end
    step();
    clear_inputs();
    #1;
    total++;
    if (flush_cnt !== 4'd1) begin bad++; $display("FAIL branch_flush_cnt got=%0d want=1", flush_cnt); end
    total++;
    if (stall_cnt !== 4'd0) begin bad++; $display("FAIL branch_stall_cnt got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) mem_req = 1'b0; // dropping the request mid-wait changes nothing
      #1;
      total++;
      if (ctrl !== C_MEM) begin bad++; $display("FAIL memwait_c%0d got=%b want=%b", i + 1, ctrl, C_MEM); end
      step();
    end
    mem_ready = 1'b1; branch_taken = 1'b0;
    #1;
    total++;
    if (ctrl !== C_NONE) begin bad++; $display("FAIL memwait_release got=%b want=%b", ctrl, C_NONE); end
    total++;
    if (stall_cnt !== 4'd4) begin bad++; $display("FAIL memwait_stall_cnt got=%0d want=4", stall_cnt); end
    total++;
    if (flush_cnt !== 4'd0) begin bad++; $display("FAIL memwait_flush_cnt got=%0d want=0", flush_cnt); end
    step();
    mem_ready = 1'b0;
    #1;
    total++;
    if (ctrl !== C_NONE) begin bad++; $display("FAIL memwait_back_run got=%b want=%b", ctrl, C_NONE); end
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      total++;
      if (ctrl !== C_MEM) begin bad++; $display("FAIL timeout_c%0d got=%b want=%b", i + 1, ctrl, C_MEM); end
      step();
    end
    #1;
    total++;
    if (ctrl !== C_NONE) begin bad++; $display("FAIL timeout_release got=%b want=%b", ctrl, C_NONE); end
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_set got=%b want=1", timeout_err); end
    total++;
    if (stall_cnt !== 4'd8) begin bad++; $display("FAIL timeout_stall_cnt got=%0d want=8", stall_cnt); end
    step();
    mem_req = 1'b0;
    step();
    step();
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_sticky got=%b want=1", timeout_err); end
    do_reset();
    #1;
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_err_cleared got=%b want=0", timeout_err); end
  endtask

  task automatic test_rst_mid_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    total++;
    if (ctrl !== C_NONE) begin bad++; $display("FAIL rstwait_ctrl got=%b want=%b", ctrl, C_NONE); end
    step();
    rst = 1'b0; mem_req = 1'b0;
    #1;
    total++;
    if (ctrl !== C_NONE) begin bad++; $display("FAIL rstwait_run got=%b want=%b", ctrl, C_NONE); end
    total++;
    if (stall_cnt !== 4'd0) begin bad++; $display("FAIL rstwait_stall_cnt got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    src1 = 4'd7; use_src1 = 1'b1; exe_dest = 4'd7; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
    for (int i = 0; i < 20; i++) step();
    total++;
    if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_stall got=%0d want=15", stall_cnt); end
    clear_inputs();
    branch_taken = 1'b1;
    for (int i = 0; i < 20; i++) step();
    total++;
    if (flush_cnt !== 4'd15) begin bad++; $display("FAIL sat_flush got=%0d want=15", flush_cnt); end
    total++;
    if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_stall_hold got=%0d want=15", stall_cnt); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_raw();
    test_branch_vs_hazard();
    test_mem_wait();
    test_timeout();
    test_rst_mid_wait();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
